sdram_port_arbiter: RTL and testbench

SDRAM_PORT_ARBITER -- requirements
Module: sdram_port_arbiter

---
 rtl/sdram_port_arbiter.sv | 151 +++++++++++++++
 tb/tb_sdram_port_arbiter.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_port_arbiter.sv
// Two-port round-robin arbiter in front of a single-transaction SDRAM controller.
// Each port holds a request until it gets a one-cycle ack. The winning port's
// command is latched, so the controller address and data stay stable for the whole
// transaction. Read data is captured into that port's ordata register.
//
// Ports:
//   iclk, ireset                     clock, asynchronous active-high reset
//   pN_ireq/iwe/iaddress/iwdata      port N request, direction, address, write data
//   pN_ordata, pN_oack               port N read data (held), completion pulse
//   owrite_req/address/data          write command to the controller
//   iwrite_ack                       controller write-done pulse
//   oread_req/address                read command to the controller
//   iread_data, iread_ack            controller read data and read-done pulse
//   ogrant                           port owning the current or last transaction
//   obusy                            high whenever the FSM is not in IDLE
//   otimeout                         sticky flag, set when the ack wait exceeds ACK_TIMEOUT
module sdram_port_arbiter #(
    parameter int unsigned ACK_TIMEOUT = 1023
) (
    input  logic         iclk,
    input  logic         ireset,
    input  logic         p0_ireq,
    input  logic         p0_iwe,
    input  logic [21:0]  p0_iaddress,
    input  logic [127:0] p0_iwdata,
    output logic [127:0] p0_ordata,
    output logic         p0_oack,
    input  logic         p1_ireq,
    input  logic         p1_iwe,
    input  logic [21:0]  p1_iaddress,
    input  logic [127:0] p1_iwdata,
    output logic [127:0] p1_ordata,
    output logic         p1_oack,
    output logic         owrite_req,
    output logic [21:0]  owrite_address,
    output logic [127:0] owrite_data,
    input  logic         iwrite_ack,
    output logic         oread_req,
    output logic [21:0]  oread_address,
    input  logic [127:0] iread_data,
    input  logic         iread_ack,
    output logic         ogrant,
    output logic         obusy,
    output logic         otimeout
);

    localparam int unsigned AW    = 22;
    localparam int unsigned DW    = 128;
    localparam int unsigned CNT_W = (ACK_TIMEOUT < 1) ? 1 : $clog2(ACK_TIMEOUT + 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t             r_state;
    logic               r_we;
    logic [AW-1:0]      r_addr;
    logic [DW-1:0]      r_wdata;
    logic [DW-1:0]      r_rdata0;
    logic [DW-1:0]      r_rdata1;
    logic               r_ack0;
    logic               r_ack1;
    logic               r_grant;
    logic               r_last;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_timeout;

    logic w_req_any;
    logic w_winner;
    logic w_in_wait;
    logic w_ack_match;

    // Round robin: on contention the port that did not win last time goes first
    assign w_req_any   = p0_ireq | p1_ireq;
    assign w_winner    = (p0_ireq & p1_ireq) ? ~r_last : ~p0_ireq;
    assign w_in_wait   = (r_state == ST_WAIT);
    assign w_ack_match = r_we ? iwrite_ack : iread_ack;

    // State, latched command, read data capture, ack pulses and timeout tracking
    always_ff @(posedge iclk or posedge ireset) begin
        if (ireset) begin
            r_state   <= ST_IDLE;
            r_we      <= 1'b0;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_rdata0  <= '0;
            r_rdata1  <= '0;
            r_ack0    <= 1'b0;
            r_ack1    <= 1'b0;
            r_grant   <= 1'b0;
            r_last    <= 1'b1;
            r_cnt     <= '0;
            r_timeout <= 1'b0;
        end else begin
            r_ack0 <= 1'b0;
            r_ack1 <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_req_any) begin
                        r_grant <= w_winner;
                        r_last  <= w_winner;
                        r_we    <= w_winner ? p1_iwe      : p0_iwe;
                        r_addr  <= w_winner ? p1_iaddress : p0_iaddress;
                        r_wdata <= w_winner ? p1_iwdata   : p0_iwdata;
                        r_cnt   <= '0;
                        r_state <= ST_ISSUE;
                    end
                end
                ST_ISSUE: r_state <= ST_WAIT;
                ST_WAIT: begin
                    if (w_ack_match) begin
                        if (!r_we) begin
                            if (r_grant) r_rdata1 <= iread_data;
                            else         r_rdata0 <= iread_data;
                        end
                        if (r_grant) r_ack1 <= 1'b1;
                        else         r_ack0 <= 1'b1;
                        r_state <= ST_DONE;
                    end else begin
                        // Saturating count; the flag stays set until reset
                        if (r_cnt != CNT_W'(ACK_TIMEOUT))
                            r_cnt <= r_cnt + CNT_W'(1);
                        if (r_cnt >= CNT_W'(ACK_TIMEOUT - 1))
                            r_timeout <= 1'b1;
                    end
                end
                ST_DONE: r_state <= ST_IDLE;
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Requests drop combinationally with the ack so the controller never re-issues
    assign owrite_req     = w_in_wait &  r_we & ~iwrite_ack;
    assign oread_req      = w_in_wait & ~r_we & ~iread_ack;
    assign owrite_address = r_addr;
    assign oread_address  = r_addr;
    assign owrite_data    = r_wdata;

    assign p0_ordata = r_rdata0;
    assign p1_ordata = r_rdata1;
    assign p0_oack   = r_ack0;
    assign p1_oack   = r_ack1;
    assign ogrant    = r_grant;
    assign obusy     = (r_state != ST_IDLE);
    assign otimeout  = r_timeout;

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Directed testbench for sdram_port_arbiter. It drives the inputs and samples the
// outputs 1 time unit after each rising edge.
module tb_sdram_port_arbiter;

    localparam int unsigned TO = 8;

    logic         iclk;
    logic         ireset;
    logic         p0_ireq, p0_iwe, p0_oack;
    logic [21:0]  p0_iaddress;
    logic [127:0] p0_iwdata, p0_ordata;
    logic         p1_ireq, p1_iwe, p1_oack;
    logic [21:0]  p1_iaddress;
    logic [127:0] p1_iwdata, p1_ordata;
    logic         owrite_req, oread_req, iwrite_ack, iread_ack;
    logic [21:0]  owrite_address, oread_address;
    logic [127:0] owrite_data, iread_data;
    logic         ogrant, obusy, otimeout;

    int n_vec;
    int n_err;

    localparam logic [127:0] D_A5   = {16{8'hA5}};
    localparam logic [127:0] D_RD   = 128'h0123456789ABCDEF0123456789ABCDEF;
    localparam logic [127:0] D_RD2  = 128'hCAFEF00DCAFEF00D1122334455667788;
    localparam logic [127:0] D_BEEF = {4{32'hDEADBEEF}};

    sdram_port_arbiter #(.ACK_TIMEOUT(TO)) dut (
        .iclk          (iclk),
        .ireset        (ireset),
        .p0_ireq       (p0_ireq),
        .p0_iwe        (p0_iwe),
        .p0_iaddress   (p0_iaddress),
        .p0_iwdata     (p0_iwdata),
        .p0_ordata     (p0_ordata),
        .p0_oack       (p0_oack),
        .p1_ireq       (p1_ireq),
        .p1_iwe        (p1_iwe),
        .p1_iaddress   (p1_iaddress),
        .p1_iwdata     (p1_iwdata),
        .p1_ordata     (p1_ordata),
        .p1_oack       (p1_oack),
        .owrite_req    (owrite_req),
        .owrite_address(owrite_address),
        .owrite_data   (owrite_data),
        .iwrite_ack    (iwrite_ack),
        .oread_req     (oread_req),
        .oread_address (oread_address),
        .iread_data    (iread_data),
        .iread_ack     (iread_ack),
        .ogrant        (ogrant),
        .obusy         (obusy),
        .otimeout      (otimeout)
    );

    initial iclk = 1'b0;
    always #5 iclk = ~iclk;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge iclk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [2:0] gseq;
        n_vec = 0;
        n_err = 0;
        ireset = 1'b1;
        p0_ireq = 1'b0; p0_iwe = 1'b0; p0_iaddress = '0; p0_iwdata = '0;
        p1_ireq = 1'b0; p1_iwe = 1'b0; p1_iaddress = '0; p1_iwdata = '0;
        iwrite_ack = 1'b0; iread_ack = 1'b0; iread_data = '0;

        // Reset state
        repeat (2) @(posedge iclk);
        #1;
        check("rst_ctrl", {owrite_req, oread_req, p0_oack, p1_oack, ogrant, obusy, otimeout}, '0);
        check("rst_addr", {owrite_address, oread_address}, '0);
        check("rst_wdata", owrite_data, '0);
        check("rst_rdata", p0_ordata | p1_ordata, '0);
        ireset = 1'b0;
        tick();

        // p0 write
        p0_ireq = 1'b1; p0_iwe = 1'b1; p0_iaddress = 22'h00010; p0_iwdata = D_A5;
        tick();
        check("wr_issue_req", owrite_req, 1'b0);
        check("wr_issue_busy", obusy, 1'b1);
        check("wr_issue_grant", ogrant, 1'b0);
        tick();
        check("wr_wait_req", owrite_req, 1'b1);
        check("wr_wait_addr", owrite_address, 22'h00010);
        check("wr_wait_data", owrite_data, D_A5);
        tick();
        check("wr_wait_hold", owrite_req, 1'b1);
        iwrite_ack = 1'b1;
        #1;
        check("wr_req_drop", owrite_req, 1'b0);
        check("wr_no_early_ack", p0_oack, 1'b0);
        tick();
        iwrite_ack = 1'b0;
        check("wr_oack", {p1_oack, p0_oack}, 2'b01);
        check("wr_done_busy", obusy, 1'b1);
        p0_ireq = 1'b0;
        tick();
        check("wr_oack_end", p0_oack, 1'b0);
        check("wr_idle_busy", obusy, 1'b0);

        // p1 read at top address
        p1_ireq = 1'b1; p1_iwe = 1'b0; p1_iaddress = 22'h3FFFFF; p1_iwdata = D_BEEF;
        tick();
        check("rd_issue_grant", ogrant, 1'b1);
        check("rd_issue_req", oread_req, 1'b0);
        tick();
        check("rd_wait_req", {owrite_req, oread_req}, 2'b01);
        check("rd_wait_addr", oread_address, 22'h3FFFFF);
        iread_data = D_RD;
        iread_ack = 1'b1;
        #1;
        check("rd_req_drop", oread_req, 1'b0);
        tick();
        iread_ack = 1'b0;
        iread_data = '1;
        check("rd_oack", {p1_oack, p0_oack}, 2'b10);
        check("rd_p1_data", p1_ordata, D_RD);
        check("rd_p0_data_kept", p0_ordata, '0);
        p1_ireq = 1'b0;
        tick();
        check("rd_oack_end", p1_oack, 1'b0);
        check("rd_data_held", p1_ordata, D_RD);

        // Acks while idle are ignored
        iwrite_ack = 1'b1; iread_ack = 1'b1;
        tick();
        iwrite_ack = 1'b0; iread_ack = 1'b0;
        check("idle_ack_busy", obusy, 1'b0);
        tick();
        check("idle_ack_oack", {p1_oack, p0_oack}, 2'b00);
        check("idle_ack_data", p1_ordata, D_RD);

        // Read ack during a write wait is ignored
        p0_ireq = 1'b1; p0_iwe = 1'b1; p0_iaddress = 22'h00155; p0_iwdata = D_BEEF;
        tick();
        tick();
        iread_data = D_RD2;
        iread_ack = 1'b1;
        #1;
        check("xack_req_stays", owrite_req, 1'b1);
        tick();
        iread_ack = 1'b0;
        check("xack_no_oack", p0_oack, 1'b0);
        check("xack_still_wait", owrite_req, 1'b1);
        check("xack_no_capture", p0_ordata, '0);
        iwrite_ack = 1'b1;
        tick();
        iwrite_ack = 1'b0;
        check("xack_wr_oack", p0_oack, 1'b1);
        p0_ireq = 1'b0;
        tick();

        // Timeout after TO wait cycles, late ack still completes
        p0_ireq = 1'b1; p0_iwe = 1'b0; p0_iaddress = 22'h0002A;
        tick();
        tick();
        repeat (TO - 1) tick();
        check("to_not_yet", otimeout, 1'b0);
        check("to_req_live", oread_req, 1'b1);
        tick();
        check("to_set", otimeout, 1'b1);
        check("to_busy", obusy, 1'b1);
        repeat (3) tick();
        check("to_sticky_wait", otimeout, 1'b1);
        iread_data = D_RD2;
        iread_ack = 1'b1;
        tick();
        iread_ack = 1'b0;
        check("to_late_oack", p0_oack, 1'b1);
        check("to_late_data", p0_ordata, D_RD2);
        check("to_sticky_done", otimeout, 1'b1);
        p0_ireq = 1'b0;
        tick();

        // Reset in the middle of a write wait
        p0_ireq = 1'b1; p0_iwe = 1'b1; p0_iaddress = 22'h00077; p0_iwdata = D_A5;
        tick();
        tick();
        check("mrst_pre_req", owrite_req, 1'b1);
        #2;
        ireset = 1'b1;
        #1;
        check("mrst_ctrl", {owrite_req, oread_req, p0_oack, p1_oack, ogrant, obusy, otimeout}, '0);
        check("mrst_addr", {owrite_address, oread_address}, '0);
        check("mrst_data", owrite_data | p0_ordata | p1_ordata, '0);
        tick();
        check("mrst_no_oack", p0_oack, 1'b0);
        ireset = 1'b0;
        tick();
        check("mrst_reissue_grant", {obusy, ogrant}, 2'b10);
        tick();
        check("mrst_reissue_req", owrite_req, 1'b1);
        check("mrst_reissue_addr", owrite_address, 22'h00077);
        iwrite_ack = 1'b1;
        tick();
        iwrite_ack = 1'b0;
        check("mrst_reissue_oack", p0_oack, 1'b1);
        p0_ireq = 1'b0;
        tick();

        // Round robin after reset: p0, p1, p0
        ireset = 1'b1;
        tick();
        ireset = 1'b0;
        tick();
        p0_ireq = 1'b1; p0_iwe = 1'b1; p0_iaddress = 22'h00100; p0_iwdata = D_A5;
        p1_ireq = 1'b1; p1_iwe = 1'b1; p1_iaddress = 22'h00200; p1_iwdata = D_BEEF;
        gseq = 3'b010;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("rr_grant", ogrant, gseq[i]);
            tick();
            check("rr_addr", owrite_address, gseq[i] ? 22'h00200 : 22'h00100);
            iwrite_ack = 1'b1;
            tick();
            iwrite_ack = 1'b0;
            check("rr_oack", {p1_oack, p0_oack}, gseq[i] ? 2'b10 : 2'b01);
            tick();
        end
        p0_ireq = 1'b0;
        p1_ireq = 1'b0;
        tick();
        check("rr_idle", obusy, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
